edge_debounce_array: RTL and testbench
======================================

EDGE_DEBOUNCE_ARRAY -- requirements
Module: edge_debounce_array

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, range 2..4.
REQ-003 Parameter DB_W, default 4: debounce counter and db_len width, range 1..16.
REQ-004 Port clk  input  1: clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1: asynchronous active-low reset.
REQ-006 Port din  input  CH: asynchronous raw inputs, one bit per channel.
REQ-007 Port db_len  input  DB_W: debounce length in cycles, shared by all channels, quasi-static.
REQ-008 Port mode  input  2*CH: per-channel event select, bits [2i+1:2i]; 00 none, 01 rising, 10 falling, 11 both.
REQ-009 Port clr  input  CH: write-1 clear of evt_flag, one bit per channel.
REQ-010 Port level  output  CH: debounced stable level per channel.
REQ-011 Port pos_edge  output  CH: one-cycle pulse on a debounced 0->1 transition, ungated by mode.
REQ-012 Port neg_edge  output  CH: one-cycle pulse on a debounced 1->0 transition, ungated by mode.
REQ-013 Port evt  output  CH: pos_edge/neg_edge pulse gated by mode.
REQ-014 Port evt_flag  output  CH: sticky event flags (see Configuration).
REQ-015 Port irq  output  1: interrupt request, registered.

Function
REQ-016 Each channel SHALL pass din[i] through SYNC_STAGES flops; s[i] is the last stage output.
REQ-017 Per channel, a DB_W-bit counter SHALL increment each cycle s[i] != level[i] and clear to 0 each cycle s[i] == level[i].
REQ-018 When s[i] != level[i] and the counter equals L-1, where L = max(db_len,1), level[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-019 A difference lasting fewer than L consecutive cycles SHALL produce no level change and no pulse (glitch rejection).
REQ-020 pos_edge/neg_edge SHALL be registered, high for exactly one cycle starting the edge after level toggles.
REQ-021 Latency: din changes before edge 0 and is held; pulse asserts after edge SYNC_STAGES+L and deasserts after the next edge.
REQ-022 evt[i] SHALL equal (pos_edge[i] & mode[2i]) | (neg_edge[i] & mode[2i+1]), registered in the same cycle as the pulse; mode is sampled at the edge where level toggles.
REQ-023 The counter SHALL never wrap: saturation at L-1 is impossible because reaching it forces the toggle and clear.
REQ-024 A db_len change mid-count SHALL take effect on the next cycle; if the counter already exceeds the new L-1, level toggles on the next edge with s != level.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-026 On rst_n low, all sync flops, counters, level, pos_edge, neg_edge, evt, evt_flag and irq SHALL clear to 0 immediately, without waiting for clk.
REQ-027 A din held high through reset release SHALL produce one rising event after the REQ-021 latency, measured from the first edge after release.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL follow release for a transition that was only partly debounced.

Configuration
REQ-029 Macro EDGE_DEBOUNCE_STICKY_EN defined: evt_flag[i] SHALL set when evt[i] is high and clear on clr[i]; set SHALL win over clear in the same cycle; irq SHALL be the registered OR of evt_flag.
REQ-030 Macro EDGE_DEBOUNCE_STICKY_EN undefined: evt_flag SHALL be tied to 0, clr SHALL be ignored, and irq SHALL be the registered OR of evt, giving a one-cycle pulse one edge after evt.

Verification
REQ-031 CH=4, SYNC_STAGES=2, db_len=3; din[0] 0->1 before edge 0 and held -> level[0]=1 after edge 4; pos_edge[0]=1 only after edge 5.
REQ-032 db_len=3; din[1] high for 2 cycles, then low -> level, pos_edge, neg_edge and evt stay 0 throughout.
REQ-033 mode=8'b00_11_10_01; rise then fall on all channels -> evt[0] on rise only, evt[1] on fall only, evt[2] on both, evt[3] never.
REQ-034 STICKY_EN defined; evt[2] pulse, then clr[2]=1 in the same cycle as a new evt[2] -> evt_flag[2] stays 1; a later clr[2] alone clears it, and irq drops one edge later.
REQ-035 din=4'hF held through reset release with db_len=0 -> pos_edge=4'hF once, after edge 3 following release.
REQ-036 rst_n pulsed low at counter value 2 of a db_len=5 transition -> all outputs 0 asynchronously; no pulse after release until 5 stable cycles have elapsed.

Source files
------------

// File: rtl/edge_debounce_array.sv
// Multi-channel input synchroniser + debouncer with edge pulses, mode-gated events and interrupt.
// Optional sticky event flags with write-1 clear: define EDGE_DEBOUNCE_STICKY_EN.
module edge_debounce_array #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     din,
  input  logic [DB_W-1:0]   db_len,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     level,
  output logic [CH-1:0]     pos_edge,
  output logic [CH-1:0]     neg_edge,
  output logic [CH-1:0]     evt,
  output logic [CH-1:0]     evt_flag,
  output logic              irq
);

  logic [DB_W-1:0] len_m1_c;
  logic [CH-1:0]   s_c;
  logic [CH-1:0]   toggle_c;
  logic [CH-1:0]   rise_en_c;
  logic [CH-1:0]   fall_en_c;
  logic [CH-1:0]   pend_pos_q;
  logic [CH-1:0]   pend_neg_q;
  logic [CH-1:0]   pend_evt_q;

  // Terminal count L-1 with db_len of 0 treated as 1.
  always_comb begin
    len_m1_c = '0;
    if (db_len != '0) begin
      len_m1_c = db_len - DB_W'(1);
    end
  end

  for (genvar i = 0; i < int'(CH); i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt_q;

    assign s_c[i]       = sync_q[SYNC_STAGES-1];
    assign rise_en_c[i] = mode[2*i];
    assign fall_en_c[i] = mode[2*i+1];
    // >= rather than == so a shortened db_len mid-count still terminates.
    assign toggle_c[i]  = (s_c[i] != level[i]) && (cnt_q >= len_m1_c);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if ((s_c[i] == level[i]) || toggle_c[i]) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  // Level update; edge and mode-gated event captured at the toggle edge, presented one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= '0;
      pend_pos_q <= '0;
      pend_neg_q <= '0;
      pend_evt_q <= '0;
      pos_edge   <= '0;
      neg_edge   <= '0;
      evt        <= '0;
    end else begin
      level      <= level ^ toggle_c;
      pend_pos_q <= toggle_c & ~level;
      pend_neg_q <= toggle_c & level;
      pend_evt_q <= (toggle_c & ~level & rise_en_c) | (toggle_c & level & fall_en_c);
      pos_edge   <= pend_pos_q;
      neg_edge   <= pend_neg_q;
      evt        <= pend_evt_q;
    end
  end

`ifdef EDGE_DEBOUNCE_STICKY_EN
  // Sticky flags: a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_flag <= '0;
      irq      <= 1'b0;
    end else begin
      evt_flag <= evt | (evt_flag & ~clr);
      irq      <= |evt_flag;
    end
  end
`else
  logic unused_clr_c;
  assign unused_clr_c = ^clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_flag <= '0;
      irq      <= 1'b0;
    end else begin
      evt_flag <= '0;
      irq      <= |evt;
    end
  end
`endif

endmodule

// File: tb/tb_edge_debounce_array.sv
// Directed, table-driven bench for edge_debounce_array (CH=4, SYNC_STAGES=2, DB_W=4).
module tb_edge_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic [3:0] db_len;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level, pos_edge, neg_edge, evt, evt_flag;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  edge_debounce_array #(.CH(4), .SYNC_STAGES(2), .DB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .db_len(db_len), .mode(mode), .clr(clr),
    .level(level), .pos_edge(pos_edge), .neg_edge(neg_edge), .evt(evt),
    .evt_flag(evt_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic [3:0] lvl;
    logic [3:0] pos;
    logic [3:0] neg;
    logic [3:0] ev;
    logic [3:0] flg;
    logic       irq;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] d, input logic [3:0] c);
    din = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_level"}, 32'(level), 32'd0);
    chk({name, "_pos"},   32'(pos_edge), 32'd0);
    chk({name, "_neg"},   32'(neg_edge), 32'd0);
    chk({name, "_evt"},   32'(evt), 32'd0);
    chk({name, "_flag"},  32'(evt_flag), 32'd0);
    chk({name, "_irq"},   32'(irq), 32'd0);
  endtask

  function automatic vec_t mk(input logic [3:0] d, input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] n, input logic [3:0] e, input logic q);
    vec_t v;
    v.din = d; v.lvl = l; v.pos = p; v.neg = n; v.ev = e; v.flg = 4'h0; v.irq = q;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Rise on all channels at step 0, fall at step 6; db_len=3 gives level after edge 4, pulse after edge 5.
    tbl[0]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[1]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[2]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[3]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[4]  = mk(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[5]  = mk(4'hF, 4'hF, 4'hF, 4'h0, 4'h5, 1'b0);
    tbl[6]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1);
    tbl[7]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[8]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[9]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[10] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[11] = mk(4'h0, 4'h0, 4'h0, 4'hF, 4'h6, 1'b0);
    tbl[12] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
`ifdef EDGE_DEBOUNCE_STICKY_EN
    for (int k = 0; k < 13; k++) begin
      tbl[k].flg = (k >= 12) ? 4'h7 : ((k >= 6) ? 4'h5 : 4'h0);
      tbl[k].irq = (k >= 7);
    end
`endif

    // Reset state, checked before any clock edge.
    rst_n  = 1'b0;
    din    = 4'h0;
    clr    = 4'h0;
    db_len = 4'd3;
    mode   = 8'b00_11_10_01;
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(4'h0, 4'h0);
    step(4'h0, 4'h0);

    // Table: latency, level, pulses and mode gating on all channels.
    for (int k = 0; k < 13; k++) begin
      step(tbl[k].din, 4'h0);
      chk($sformatf("tbl%0d_level", k), 32'(level),    32'(tbl[k].lvl));
      chk($sformatf("tbl%0d_pos", k),   32'(pos_edge), 32'(tbl[k].pos));
      chk($sformatf("tbl%0d_neg", k),   32'(neg_edge), 32'(tbl[k].neg));
      chk($sformatf("tbl%0d_evt", k),   32'(evt),      32'(tbl[k].ev));
      chk($sformatf("tbl%0d_flag", k),  32'(evt_flag), 32'(tbl[k].flg));
      chk($sformatf("tbl%0d_irq", k),   32'(irq),      32'(tbl[k].irq));
    end

    // Glitch rejection: din[1] high for only two cycles.
    step(4'h2, 4'h0);
    step(4'h2, 4'h0);
    for (int k = 0; k < 10; k++) begin
      step(4'h0, 4'h0);
      chk($sformatf("glitch%0d", k), 32'({level, pos_edge, neg_edge, evt}), 32'd0);
    end

    // Clear all flags, then evt[2] twice with clr[2] coinciding with the second event.
    step(4'h0, 4'hF);
    chk("clr_all_flag", 32'(evt_flag), 32'd0);
    step(4'h0, 4'h0);
    chk("clr_all_irq", 32'(irq), 32'd0);

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(4'h4, 4'h0);
      found = evt[2];
    end
    chk("rise2_found", 32'(found), 32'd1);
    chk("rise2_evt", 32'(evt), 32'h4);
    step(4'h4, 4'h0);
`ifdef EDGE_DEBOUNCE_STICKY_EN
    chk("rise2_flag", 32'(evt_flag), 32'h4);
    chk("rise2_irq", 32'(irq), 32'd0);
`else
    chk("rise2_flag", 32'(evt_flag), 32'h0);
    chk("rise2_irq", 32'(irq), 32'd1);
`endif

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(4'h0, 4'h0);
      found = evt[2];
    end
    chk("fall2_found", 32'(found), 32'd1);
    chk("fall2_neg", 32'(neg_edge), 32'h4);
    step(4'h0, 4'h4);
`ifdef EDGE_DEBOUNCE_STICKY_EN
    chk("set_wins_flag", 32'(evt_flag), 32'h4);
`else
    chk("set_wins_flag", 32'(evt_flag), 32'h0);
`endif
    step(4'h0, 4'h0);
    step(4'h0, 4'h4);
    chk("clr2_flag", 32'(evt_flag), 32'h0);
`ifdef EDGE_DEBOUNCE_STICKY_EN
    chk("clr2_irq_hold", 32'(irq), 32'd1);
`else
    chk("clr2_irq_hold", 32'(irq), 32'd0);
`endif
    step(4'h0, 4'h0);
    chk("clr2_irq_drop", 32'(irq), 32'd0);

    // din=F held through reset release with db_len=0: pulse after edge 3.
    db_len = 4'd0;
    #2 rst_n = 1'b0;
    step(4'hF, 4'h0);
    chk_all_zero("hold_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 4'h0);
      chk($sformatf("rel%0d_level", k), 32'(level), (k >= 2) ? 32'hF : 32'h0);
      chk($sformatf("rel%0d_pos", k), 32'(pos_edge), (k == 3) ? 32'hF : 32'h0);
    end
    chk("rel_level_set", 32'(level), 32'hF);

    // Asynchronous clear mid-cycle with level high.
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(4'h0, 4'h0);
    rst_n = 1'b1;
    step(4'h0, 4'h0);
    step(4'h0, 4'h0);

    // Reset mid-debounce (count 2 of db_len=5): full debounce needed again afterwards.
    db_len = 4'd5;
    for (int k = 0; k < 4; k++) step(4'hF, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(4'hF, 4'h0);
      chk($sformatf("mid%0d_level", k), 32'(level), (k >= 6) ? 32'hF : 32'h0);
      chk($sformatf("mid%0d_pos", k), 32'(pos_edge), (k == 7) ? 32'hF : 32'h0);
      chk($sformatf("mid%0d_evt", k), 32'(evt), (k == 7) ? 32'h5 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
